// File: rtl/poll_port_servicer.sv
// rtl/poll_port_servicer.sv - services one-hot poll strobes, forwards port requests upstream, returns ack/nak
module poll_port_servicer #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            poll_sel,
    input  logic [NUM_PORTS-1:0]            port_req,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
    output logic [NUM_PORTS-1:0]            port_ack,
    output logic [NUM_PORTS-1:0]            port_nak,
    output logic                            up_valid,
    output logic [DATA_WIDTH-1:0]           up_data,
    output logic [$clog2(NUM_PORTS)-1:0]    up_port,
    input  logic                            up_ready,
    output logic                            busy,
    output logic                            err_multi_hot,
    output logic                            missed_poll
);

    localparam int IDX_W   = $clog2(NUM_PORTS);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEND,
        S_ACK,
        S_NAK
    } state_t;

    state_t                 state, state_d;
    logic [NUM_PORTS-1:0]   poll_q;
    logic [NUM_PORTS-1:0]   new_edge;
    logic                   new_multi;
    logic [IDX_W-1:0]       new_idx;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [TIMER_W-1:0]     timer, timer_d;
    logic [DATA_WIDTH-1:0]  up_data_q, up_data_d;
    logic [IDX_W-1:0]       up_port_q, up_port_d;
    logic [DATA_WIDTH-1:0]  sel_word;
    logic                   err_q, err_d;
    logic                   missed_q, missed_d;

    // Rising bits of the poll strobe; poll_q clears in reset so a held strobe re-fires on release
    assign new_edge  = poll_sel & ~poll_q;
    assign new_multi = (new_edge & (new_edge - NUM_PORTS'(1))) != '0;

    // Encode the rising strobe bit and pick the word of the port being serviced
    always_comb begin
        new_idx  = '0;
        sel_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (new_edge[i]) begin
                new_idx = IDX_W'(i);
            end
            if (idx == IDX_W'(i)) begin
                sel_word = port_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and datapath updates for the poll service sequence
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        timer_d   = timer;
        up_data_d = up_data_q;
        up_port_d = up_port_q;
        err_d     = 1'b0;
        missed_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_edge != '0) begin
                    if (new_multi) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = new_idx;
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (port_req[idx]) begin
                    up_data_d = sel_word;
                    up_port_d = idx;
                    timer_d   = '0;
                    state_d   = S_SEND;
                end else begin
                    state_d = S_NAK;
                end
            end
            S_SEND: begin
                if (up_ready) begin
                    state_d = S_ACK;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    state_d = S_NAK;
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_NAK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Polls arriving while a transfer is in flight are flagged and dropped, never queued
        if (state != S_IDLE && new_edge != '0) begin
            missed_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            poll_q    <= '0;
            idx       <= '0;
            timer     <= '0;
            up_data_q <= '0;
            up_port_q <= '0;
            err_q     <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state     <= state_d;
            poll_q    <= poll_sel;
            idx       <= idx_d;
            timer     <= timer_d;
            up_data_q <= up_data_d;
            up_port_q <= up_port_d;
            err_q     <= err_d;
            missed_q  <= missed_d;
        end
    end

    assign up_valid      = (state == S_SEND);
    assign busy          = (state != S_IDLE);
    assign up_data       = up_data_q;
    assign up_port       = up_port_q;
    assign port_ack      = (state == S_ACK) ? (NUM_PORTS'(1) << idx) : '0;
    assign port_nak      = (state == S_NAK) ? (NUM_PORTS'(1) << idx) : '0;
    assign err_multi_hot = err_q;
    assign missed_poll   = missed_q;

endmodule

// File: tb/tb_poll_port_servicer.sv
// tb/tb_poll_port_servicer.sv - directed self-checking bench for poll_port_servicer
module tb_poll_port_servicer;

    logic        clock;
    logic        reset_n;
    logic [3:0]  poll_sel;
    logic [3:0]  port_req;
    logic [31:0] port_data;
    logic [3:0]  port_ack;
    logic [3:0]  port_nak;
    logic        up_valid;
    logic [7:0]  up_data;
    logic [1:0]  up_port;
    logic        up_ready;
    logic        busy;
    logic        err_multi_hot;
    logic        missed_poll;

    int checks;
    int errors;

    poll_port_servicer #(.NUM_PORTS(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .poll_sel(poll_sel),
        .port_req(port_req),
        .port_data(port_data),
        .port_ack(port_ack),
        .port_nak(port_nak),
        .up_valid(up_valid),
        .up_data(up_data),
        .up_port(up_port),
        .up_ready(up_ready),
        .busy(busy),
        .err_multi_hot(err_multi_hot),
        .missed_poll(missed_poll)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            poll_sel  = 4'($urandom);
            port_req  = 4'($urandom);
            port_data = $urandom;
            up_ready  = 1'($urandom);
            if (i == 4) poll_sel = 4'b0001;
            step();
            checks++;
            if ({port_ack, port_nak, up_valid, up_data, up_port, busy, err_multi_hot, missed_poll} !== 26'd0) begin
                errors++;
                $display("FAIL reset_outputs: got ack=%b nak=%b v=%b d=%h p=%0d busy=%b err=%b miss=%b, want all 0",
                         port_ack, port_nak, up_valid, up_data, up_port, busy, err_multi_hot, missed_poll);
            end
        end
        reset_n  = 1'b1;
        port_req = 4'b0000;
        up_ready = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_edge: busy=%b want 1", busy);
        end
        step();
        checks++;
        if (port_nak !== 4'b0001 || up_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_nak: nak=%b valid=%b want 0001/0", port_nak, up_valid);
        end
        step();
        checks++;
        if (busy !== 1'b0 || port_nak !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b nak=%b want 0/0000", busy, port_nak);
        end
        poll_sel = 4'b0000;
        step();
    endtask

    task automatic test_ack_path;
        port_data = 32'h44A52211;
        port_req  = 4'b0100;
        up_ready  = 1'b1;
        poll_sel  = 4'b0100;
        step();
        checks++;
        if (busy !== 1'b1 || up_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_capture: busy=%b valid=%b want 1/0", busy, up_valid);
        end
        step();
        checks++;
        if (up_valid !== 1'b1 || up_data !== 8'hA5 || up_port !== 2'd2) begin
            errors++;
            $display("FAIL ack_send: valid=%b data=%h port=%0d want 1/a5/2", up_valid, up_data, up_port);
        end
        port_data = 32'h44002211;
        step();
        checks++;
        if (up_valid !== 1'b0 || port_ack !== 4'b0100 || port_nak !== 4'b0000 || up_data !== 8'hA5) begin
            errors++;
            $display("FAIL ack_pulse: valid=%b ack=%b nak=%b data=%h want 0/0100/0000/a5",
                     up_valid, port_ack, port_nak, up_data);
        end
        step();
        checks++;
        if (port_ack !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_done: ack=%b busy=%b want 0000/0", port_ack, busy);
        end
        poll_sel = 4'b0000;
        up_ready = 1'b0;
        step();
    endtask

    task automatic test_no_request;
        port_req = 4'b0000;
        up_ready = 1'b1;
        poll_sel = 4'b0010;
        step();
        step();
        checks++;
        if (port_nak !== 4'b0010 || port_ack !== 4'b0000 || up_valid !== 1'b0) begin
            errors++;
            $display("FAIL noreq_nak: nak=%b ack=%b valid=%b want 0010/0000/0", port_nak, port_ack, up_valid);
        end
        step();
        checks++;
        if (port_nak !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL noreq_done: nak=%b busy=%b want 0000/0", port_nak, busy);
        end
        poll_sel = 4'b0000;
        up_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout;
        for (int rep = 0; rep < 2; rep++) begin
            int vcnt;
            vcnt      = 0;
            port_data = 32'h44332211;
            port_req  = 4'b1000;
            up_ready  = 1'b0;
            poll_sel  = 4'b1000;
            step();
            for (int i = 0; i < 16; i++) begin
                step();
                if (up_valid === 1'b1 && up_data === 8'h44 && up_port === 2'd3) vcnt++;
                if (rep == 1 && i == 15) up_ready = 1'b1;
            end
            checks++;
            if (vcnt != 16) begin
                errors++;
                $display("FAIL timeout_valid_cycles rep%0d: got %0d want 16", rep, vcnt);
            end
            step();
            checks++;
            if (rep == 0 && (up_valid !== 1'b0 || port_nak !== 4'b1000 || port_ack !== 4'b0000)) begin
                errors++;
                $display("FAIL timeout_nak: valid=%b nak=%b ack=%b want 0/1000/0000", up_valid, port_nak, port_ack);
            end
            if (rep == 1 && (up_valid !== 1'b0 || port_ack !== 4'b1000 || port_nak !== 4'b0000)) begin
                errors++;
                $display("FAIL timeout_last_ready: valid=%b ack=%b nak=%b want 0/1000/0000", up_valid, port_ack, port_nak);
            end
            poll_sel = 4'b0000;
            up_ready = 1'b0;
            step();
            checks++;
            if (busy !== 1'b0 || port_ack !== 4'b0000 || port_nak !== 4'b0000) begin
                errors++;
                $display("FAIL timeout_done rep%0d: busy=%b ack=%b nak=%b want idle", rep, busy, port_ack, port_nak);
            end
        end
    endtask

    task automatic test_hazards;
        poll_sel = 4'b0011;
        step();
        checks++;
        if (err_multi_hot !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL multi_hot: err=%b busy=%b want 1/0", err_multi_hot, busy);
        end
        step();
        checks++;
        if (err_multi_hot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL multi_hot_clear: err=%b busy=%b want 0/0", err_multi_hot, busy);
        end
        poll_sel = 4'b0000;
        step();

        port_data = 32'h44332211;
        port_req  = 4'b0001;
        up_ready  = 1'b0;
        poll_sel  = 4'b0001;
        step();
        step();
        poll_sel = 4'b0011;
        step();
        checks++;
        if (missed_poll !== 1'b1 || up_valid !== 1'b1 || up_port !== 2'd0) begin
            errors++;
            $display("FAIL missed_poll: miss=%b valid=%b port=%0d want 1/1/0", missed_poll, up_valid, up_port);
        end
        up_ready = 1'b1;
        step();
        checks++;
        if (missed_poll !== 1'b0 || port_ack !== 4'b0001 || port_nak !== 4'b0000) begin
            errors++;
            $display("FAIL missed_complete: miss=%b ack=%b nak=%b want 0/0001/0000", missed_poll, port_ack, port_nak);
        end
        step();
        checks++;
        if (busy !== 1'b0 || port_ack !== 4'b0000 || port_nak !== 4'b0000) begin
            errors++;
            $display("FAIL missed_discarded: busy=%b ack=%b nak=%b want idle", busy, port_ack, port_nak);
        end
        poll_sel = 4'b0000;
        up_ready = 1'b0;
        step();

        port_req = 4'b0100;
        poll_sel = 4'b0100;
        step();
        step();
        checks++;
        if (up_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: valid=%b want 1", up_valid);
        end
        reset_n  = 1'b0;
        poll_sel = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b0 || up_valid !== 1'b0 || port_ack !== 4'b0000 || port_nak !== 4'b0000) begin
            errors++;
            $display("FAIL abort_reset: busy=%b valid=%b ack=%b nak=%b want idle", busy, up_valid, port_ack, port_nak);
        end
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || port_ack !== 4'b0000 || port_nak !== 4'b0000) begin
            errors++;
            $display("FAIL abort_silent: busy=%b ack=%b nak=%b want idle", busy, port_ack, port_nak);
        end
    endtask

    task automatic test_rotation;
        logic [3:0] req_tab [5];
        logic [7:0] word_tab [4];
        req_tab   = '{4'b0101, 4'b1101, 4'b0100, 4'b1010, 4'b0110};
        word_tab  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        port_data = 32'hD4C3B2A1;
        poll_sel  = 4'b0000;
        step();
        for (int s = 0; s < 5; s++) begin
            int port, ack_cnt, nak_cnt, stray;
            logic hs, done, req_bit;
            logic [3:0] mask;
            port     = s % 4;
            mask     = 4'b0001 << port;
            req_bit  = (req_tab[s] & mask) != 4'b0000;
            ack_cnt  = 0;
            nak_cnt  = 0;
            stray    = 0;
            hs       = 1'b0;
            done     = 1'b0;
            port_req = req_tab[s];
            poll_sel = mask;
            for (int c = 0; c < 40 && !done; c++) begin
                up_ready = 1'($urandom_range(0, 1));
                if (up_valid === 1'b1 && up_ready) hs = 1'b1;
                step();
                if (port_ack === mask) ack_cnt++;
                else if (port_ack !== 4'b0000) stray++;
                if (port_nak === mask) nak_cnt++;
                else if (port_nak !== 4'b0000) stray++;
                if (err_multi_hot !== 1'b0 || missed_poll !== 1'b0) stray++;
                if (up_valid === 1'b1) begin
                    checks++;
                    if (up_data !== word_tab[port] || up_port !== 2'(port) || !req_bit) begin
                        errors++;
                        $display("FAIL rot_data slot%0d: data=%h port=%0d req=%b want %h/%0d/1",
                                 s, up_data, up_port, req_bit, word_tab[port], port);
                    end
                end
                if ((ack_cnt + nak_cnt) > 0 && busy === 1'b0) done = 1'b1;
            end
            checks++;
            if (!done || stray != 0) begin
                errors++;
                $display("FAIL rot_complete slot%0d: done=%b stray=%0d want 1/0", s, done, stray);
            end
            checks++;
            if (ack_cnt != ((req_bit && hs) ? 1 : 0) || nak_cnt != ((req_bit && hs) ? 0 : 1)) begin
                errors++;
                $display("FAIL rot_response slot%0d: acks=%0d naks=%0d req=%b hs=%b", s, ack_cnt, nak_cnt, req_bit, hs);
            end
        end
        poll_sel = 4'b0000;
        up_ready = 1'b0;
        step();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        poll_sel  = '0;
        port_req  = '0;
        port_data = '0;
        up_ready  = 1'b0;
        test_reset();
        test_ack_path();
        test_no_request();
        test_timeout();
        test_hazards();
        test_rotation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
